wb_stage_p: RTL

WB_STAGE_P -- requirements
Module: wb_stage_p

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_load_align.sv | 58 +++++
 rtl/wb_stage_p.sv | 112 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load funct3 encodings,
// FSM states and the link-address offset used by jal/jalr.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam int LINK_OFFSET = 4;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word/double out of
// an aligned memory word, extends it, and flags misaligned or illegal loads.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  rdata,
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] offset,
    output logic [XLEN-1:0]  data,
    output logic             misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        // Bring the addressed bytes down to bit 0 so every size reads from the LSBs.
        shifted    = rdata >> {offset, 3'b000};
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = XLEN'($signed(shifted[7:0]));
            F3_LBU: data = XLEN'(shifted[7:0]);
            F3_LH: begin
                misaligned = offset[0];
                data       = XLEN'($signed(shifted[15:0]));
            end
            F3_LHU: begin
                misaligned = offset[0];
                data       = XLEN'(shifted[15:0]);
            end
            F3_LW: begin
                misaligned = (offset[1:0] != 2'b00);
                data       = XLEN'($signed(shifted[31:0]));
            end
            F3_LWU: begin
                if (XLEN == 64) begin
                    misaligned = (offset[1:0] != 2'b00);
                    data       = XLEN'(shifted[31:0]);
                end else begin
                    misaligned = 1'b1;
                end
            end
            F3_LD: begin
                if (XLEN == 64) begin
                    misaligned = (offset != '0);
                    data       = rdata;
                end else begin
                    misaligned = 1'b1;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage_p.sv
// Write-back pipeline stage: registers ALU/link results into the register file
// and waits for memory responses on loads, counting retired instructions.
module wb_stage_p
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_regwrite,
    input  logic              in_memtoreg,
    input  logic              in_jal,
    input  logic              in_jalr,
    input  logic [2:0]        in_funct3,
    input  logic [OFF_W-1:0]  in_addr_lo,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [XLEN-1:0]   in_alu,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    state_t           state;
    state_t           next_state;
    logic [RA_W-1:0]  lat_rd;
    logic             lat_regwrite;
    logic [2:0]       lat_funct3;
    logic [OFF_W-1:0] lat_offset;
    logic             accept;
    logic             load_done;
    logic [2:0]       sel_funct3;
    logic [OFF_W-1:0] sel_offset;
    logic [XLEN-1:0]  load_data;
    logic             load_misaligned;

    assign in_ready  = rst_n && (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign load_done = (state == WAIT_MEM) && mem_rvalid;

    // One aligner serves both the accept-time alignment check and the data path.
    assign sel_funct3 = (state == WAIT_MEM) ? lat_funct3 : in_funct3;
    assign sel_offset = (state == WAIT_MEM) ? lat_offset : in_addr_lo;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .rdata      (mem_rdata),
        .funct3     (sel_funct3),
        .offset     (sel_offset),
        .data       (load_data),
        .misaligned (load_misaligned)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (accept && in_memtoreg && !load_misaligned) next_state = WAIT_MEM;
            WAIT_MEM: if (mem_rvalid) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            misalign_err <= 1'b0;
            retire_cnt   <= '0;
            lat_rd       <= '0;
            lat_regwrite <= 1'b0;
            lat_funct3   <= '0;
            lat_offset   <= '0;
        end else begin
            state        <= next_state;
            rf_we        <= 1'b0;
            misalign_err <= 1'b0;
            if (accept && !in_memtoreg) begin
                rf_we      <= in_regwrite && (in_rd != '0);
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (in_regwrite && (in_rd != '0)) begin
                    rf_waddr <= in_rd;
                    rf_wdata <= (in_jal || in_jalr) ? in_pc + XLEN'(LINK_OFFSET) : in_alu;
                end
            end else if (accept && load_misaligned) begin
                misalign_err <= 1'b1;
            end else if (accept) begin
                lat_rd       <= in_rd;
                lat_regwrite <= in_regwrite;
                lat_funct3   <= in_funct3;
                lat_offset   <= in_addr_lo;
            end else if (load_done) begin
                rf_we      <= lat_regwrite && (lat_rd != '0);
                retire_cnt <= retire_cnt + CNT_W'(1);
                if (lat_regwrite && (lat_rd != '0)) begin
                    rf_waddr <= lat_rd;
                    rf_wdata <= load_data;
                end
            end
        end
    end

endmodule
